uart_rx_frame_sampler: RTL

//  Front end of the UART receive path: synchronises the serial line, detects the start bit,
//  mid-bit samples data (LSB first) and optional parity using an oversampling tick, and

---
 rtl/uart_rx_frame_sampler_if.sv | 37 +++
 rtl/uart_rx_frame_sampler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_sampler_if.sv
// Bundle between the serial line / tick source and the UART frame sampler.
// The slave side is the sampler; the master side feeds the line and tick
// and observes the frame results.
interface uart_rx_frame_sampler_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 rx_in;
    logic                 sample_tick;
    logic [DATA_BITS-1:0] data_out;
    logic                 check_stop;
    logic                 stop_sample;
    logic                 parity_err;
    logic                 framing_err;
    logic                 busy;

    modport master (
        output rx_in,
        output sample_tick,
        input  data_out,
        input  check_stop,
        input  stop_sample,
        input  parity_err,
        input  framing_err,
        input  busy
    );

    modport slave (
        input  rx_in,
        input  sample_tick,
        output data_out,
        output check_stop,
        output stop_sample,
        output parity_err,
        output framing_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_frame_sampler.sv
// UART receive front end: synchronises the serial line, qualifies the start
// bit at its midpoint, samples data (LSB first) and optional parity at each
// bit centre, and hands the byte plus the stop-bit sample to the stop checker.
// All state advances only on sample_tick; without a tick the block holds.
module uart_rx_frame_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_rx_frame_sampler_if.slave   bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             ODD_BIT   = (PARITY_ODD != 0);
    localparam logic             HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_acc_q, par_acc_d;
    logic                 par_mis_q, par_mis_d;
    logic                 check_q, check_d;
    logic                 stop_q, stop_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_meta, rxs;
    logic                 mid_bit;

    // Two-flop synchroniser; the line idles high so both flops reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= bus.rx_in;
            rxs     <= rx_meta;
        end
    end

    // State, counters, shift register and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_acc_q <= 1'b0;
            par_mis_q <= 1'b0;
            check_q   <= 1'b0;
            stop_q    <= 1'b1;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_acc_q <= par_acc_d;
            par_mis_q <= par_mis_d;
            check_q   <= check_d;
            stop_q    <= stop_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign mid_bit = (tick_q == BIT_LAST);

    // Next-state logic: each tick either advances the oversample counter or,
    // at a sample point, consumes the bit and moves on (the tick is not reused).
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_acc_d = par_acc_q;
        par_mis_d = par_mis_q;
        check_d   = 1'b0;
        ferr_d    = 1'b0;
        stop_d    = stop_q;
        perr_d    = perr_q;

        if (bus.sample_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_LAST) begin
                        tick_d = '0;
                        if (rxs) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            idx_d     = '0;
                            par_acc_d = 1'b0;
                            par_mis_d = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (mid_bit) begin
                        shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
                        par_acc_d = par_acc_q ^ rxs;
                        tick_d    = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = HAS_PAR ? PARITY : STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (mid_bit) begin
                        par_mis_d = rxs ^ (par_acc_q ^ ODD_BIT);
                        tick_d    = '0;
                        state_d   = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (mid_bit) begin
                        check_d = 1'b1;
                        stop_d  = rxs;
                        ferr_d  = ~rxs;
                        perr_d  = HAS_PAR ? par_mis_q : 1'b0;
                        tick_d  = '0;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    assign bus.data_out    = shift_q;
    assign bus.check_stop  = check_q;
    assign bus.stop_sample = stop_q;
    assign bus.parity_err  = perr_q;
    assign bus.framing_err = ferr_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
